input_vc_unit: RTL and testbench

//  Parametrised multi-virtual-channel router input port. Buffers incoming flits in per-VC FIFOs.

---
 rtl/input_vc_unit_if.sv | 38 +++
 rtl/input_vc_unit.sv | 167 ++++++++++++++++
 tb/tb_input_vc_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/input_vc_unit_if.sv
// Router input-port bundle: upstream flit/credit link, switch-allocator request/grant and crossbar output.
// slave is the input-port view, master is the driving environment's view.
interface input_vc_unit_if #(
   parameter int NUM_VCS   = 2,
   parameter int FLIT_W    = 32,
   parameter int PORT_BITS = 3
);
   localparam int VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

   logic                           i_flit_valid;
   logic [VC_W-1:0]                i_flit_vc;
   logic [FLIT_W-1:0]              i_flit;
   logic [NUM_VCS-1:0]             o_sa_req;
   logic [NUM_VCS*PORT_BITS-1:0]   o_sa_route;
   logic [NUM_VCS-1:0]             i_sa_grant;
   logic                           o_flit_valid;
   logic [FLIT_W-1:0]              o_flit;
   logic [VC_W-1:0]                o_flit_vc;
   logic [PORT_BITS-1:0]           o_flit_route;
   logic                           i_xbar_ready;
   logic                           o_credit_valid;
   logic [VC_W-1:0]                o_credit_vc;
   logic [2*NUM_VCS-1:0]           o_vc_state;
   logic [NUM_VCS-1:0]             o_packet_done;
   logic [1:0]                     o_err;

   modport slave (
      input  i_flit_valid, i_flit_vc, i_flit, i_sa_grant, i_xbar_ready,
      output o_sa_req, o_sa_route, o_flit_valid, o_flit, o_flit_vc, o_flit_route,
             o_credit_valid, o_credit_vc, o_vc_state, o_packet_done, o_err
   );

   modport master (
      output i_flit_valid, i_flit_vc, i_flit, i_sa_grant, i_xbar_ready,
      input  o_sa_req, o_sa_route, o_flit_valid, o_flit, o_flit_vc, o_flit_route,
             o_credit_valid, o_credit_vc, o_vc_state, o_packet_done, o_err
   );
endinterface

// File: rtl/input_vc_unit.sv
// Multi-VC router input port: per-VC flit FIFOs and packet FSMs, switch-allocator requests,
// round-robin selection of one ACTIVE VC onto the crossbar, and one registered credit per dequeue.
module input_vc_unit #(
   parameter int NUM_VCS   = 2,
   parameter int BUF_DEPTH = 4,
   parameter int FLIT_W    = 32,
   parameter int PORT_BITS = 3
) (
   input logic             clk,
   input logic             reset_n,
   input_vc_unit_if.slave  bus
);
   localparam int VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ROUTING = 2'd1, WAITING = 2'd2, ACTIVE = 2'd3} vc_state_e;
   typedef enum logic [1:0] {HEAD = 2'b00, BODY = 2'b01, TAIL = 2'b10, HEAD_TAIL = 2'b11} flit_type_e;

   logic [FLIT_W-1:0]    mem_q    [NUM_VCS][BUF_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q [NUM_VCS];
   logic [PTR_W-1:0]     rd_ptr_q [NUM_VCS];
   logic [CNT_W-1:0]     count_q  [NUM_VCS];
   vc_state_e            state_q  [NUM_VCS];
   vc_state_e            state_d  [NUM_VCS];
   logic [PORT_BITS-1:0] route_q  [NUM_VCS];
   logic [PORT_BITS-1:0] route_d  [NUM_VCS];
   logic [VC_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic                 credit_valid_q;
   logic [VC_W-1:0]      credit_vc_q;

   logic [FLIT_W-1:0]    head      [NUM_VCS];
   flit_type_e           head_type [NUM_VCS];
   logic [NUM_VCS-1:0]   not_empty, full, eligible, bad_head, push_vec, pop_vec, done_vec;
   logic                 any_eligible, xfer, disc_any, disc_valid, deq, push_req, push_ok;
   logic [VC_W-1:0]      win_vc, disc_vc, deq_vc;
   int                   arb_idx;

   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         head[v]      = mem_q[v][rd_ptr_q[v]];
         head_type[v] = flit_type_e'(head[v][FLIT_W-2 -: 2]);
         not_empty[v] = (count_q[v] != '0);
         full[v]      = (count_q[v] == CNT_W'(BUF_DEPTH));
         eligible[v]  = (state_q[v] == ACTIVE) && not_empty[v];
         bad_head[v]  = (state_q[v] == IDLE) && not_empty[v] &&
                        ((head_type[v] == BODY) || (head_type[v] == TAIL));
      end
   end

   // Round-robin: the first eligible VC at or after the pointer wins.
   always_comb begin
      any_eligible = 1'b0;
      win_vc       = '0;
      arb_idx      = 0;
      for (int i = 0; i < NUM_VCS; i++) begin
         arb_idx = int'(rr_ptr_q) + i;
         if (arb_idx >= NUM_VCS) arb_idx = arb_idx - NUM_VCS;
         if (!any_eligible && eligible[arb_idx]) begin
            any_eligible = 1'b1;
            win_vc       = VC_W'(arb_idx);
         end
      end
   end

   // Protocol discards yield to a transfer, so only one FIFO is popped per cycle.
   always_comb begin
      disc_any = 1'b0;
      disc_vc  = '0;
      for (int v = NUM_VCS - 1; v >= 0; v--) begin
         if (bad_head[v]) begin
            disc_any = 1'b1;
            disc_vc  = VC_W'(v);
         end
      end
   end

   assign xfer       = any_eligible & bus.i_xbar_ready;
   assign disc_valid = disc_any & ~xfer;
   assign deq        = xfer | disc_valid;
   assign deq_vc     = xfer ? win_vc : disc_vc;
   assign rr_ptr_d   = !xfer ? rr_ptr_q :
                       (int'(win_vc) == NUM_VCS - 1) ? '0 : win_vc + VC_W'(1);

   // A full VC still takes the write when it is popped in the same cycle.
   assign push_req = bus.i_flit_valid & bus.i_flit[FLIT_W-1];
   assign push_ok  = push_req && (int'(bus.i_flit_vc) < NUM_VCS) &&
                     (!full[bus.i_flit_vc] || (deq && (deq_vc == bus.i_flit_vc)));

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         push_vec[v] = push_ok && (bus.i_flit_vc == VC_W'(v));
         pop_vec[v]  = deq && (deq_vc == VC_W'(v));
         done_vec[v] = xfer && (win_vc == VC_W'(v)) &&
                       ((head_type[v] == TAIL) || (head_type[v] == HEAD_TAIL));
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         state_d[v] = state_q[v];
         route_d[v] = route_q[v];
         unique case (state_q[v])
            IDLE:    if (not_empty[v] && ((head_type[v] == HEAD) || (head_type[v] == HEAD_TAIL)))
                        state_d[v] = ROUTING;
            ROUTING: begin
                        route_d[v] = head[v][PORT_BITS-1:0];
                        state_d[v] = WAITING;
                     end
            WAITING: if (bus.i_sa_grant[v]) state_d[v] = ACTIVE;
            ACTIVE:  if (done_vec[v]) state_d[v] = IDLE;
            default: state_d[v] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            state_q[v]  <= IDLE;
            route_q[v]  <= '0;
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            count_q[v]  <= '0;
         end
         rr_ptr_q       <= '0;
         credit_valid_q <= 1'b0;
         credit_vc_q    <= '0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            state_q[v] <= state_d[v];
            route_q[v] <= route_d[v];
            if (push_vec[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
            if (pop_vec[v])  rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
            count_q[v] <= count_q[v] + CNT_W'(push_vec[v]) - CNT_W'(pop_vec[v]);
         end
         rr_ptr_q       <= rr_ptr_d;
         credit_valid_q <= deq;
         credit_vc_q    <= deq ? deq_vc : '0;
      end
   end

   // NOTE: the flit storage has no reset; the zeroed counts already mark every slot empty.
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VCS; v++) begin
         if (push_vec[v]) mem_q[v][wr_ptr_q[v]] <= bus.i_flit;
      end
   end

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         bus.o_sa_req[v]                          = (state_q[v] == WAITING);
         bus.o_sa_route[v*PORT_BITS +: PORT_BITS] = route_q[v];
         bus.o_vc_state[2*v +: 2]                 = state_q[v];
      end
   end

   assign bus.o_flit_valid   = any_eligible;
   assign bus.o_flit         = any_eligible ? head[win_vc] : '0;
   assign bus.o_flit_vc      = win_vc;
   assign bus.o_flit_route   = any_eligible ? route_q[win_vc] : '0;
   assign bus.o_credit_valid = credit_valid_q;
   assign bus.o_credit_vc    = credit_vc_q;
   assign bus.o_packet_done  = done_vec;
   assign bus.o_err          = {disc_valid, push_req & ~push_ok};
endmodule

// File: tb/tb_input_vc_unit.sv
// Directed bench for input_vc_unit: a cycle table for a full 4-flit packet, then hand-written
// sequences for VC interleaving, overflow, protocol discard, crossbar backpressure and mid-packet reset.
module tb_input_vc_unit;
   localparam int NUM_VCS = 2, BUF_DEPTH = 4, FLIT_W = 32, PORT_BITS = 3;

   logic clk, reset_n;
   int   total = 0, bad = 0;

   input_vc_unit_if #(.NUM_VCS(NUM_VCS), .FLIT_W(FLIT_W), .PORT_BITS(PORT_BITS)) bus ();

   input_vc_unit #(.NUM_VCS(NUM_VCS), .BUF_DEPTH(BUF_DEPTH), .FLIT_W(FLIT_W), .PORT_BITS(PORT_BITS)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fv;     logic       vc;   logic [31:0] flit;  logic [1:0] grant; logic ready;
      logic [1:0]  e_req;  logic [5:0] e_sa_route; logic e_fv; logic [31:0] e_flit; logic e_fvc;
      logic [2:0]  e_froute; logic e_cv; logic e_cvc; logic [3:0] e_state; logic [1:0] e_done;
      logic [1:0]  e_err;
   } vec_t;

   function automatic logic [31:0] fl(input logic [1:0] ty, input logic [25:0] pay, input logic [2:0] rt);
      return {1'b1, ty, pay, rt};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fv, input logic vc, input logic [31:0] flit,
                        input logic [1:0] grant, input logic ready);
      @(negedge clk);
      bus.i_flit_valid = fv;
      bus.i_flit_vc    = vc;
      bus.i_flit       = flit;
      bus.i_sa_grant   = grant;
      bus.i_xbar_ready = ready;
      #1;
   endtask

   task automatic idle(input logic [1:0] grant, input logic ready);
      drive(1'b0, 1'b0, 32'h0, grant, ready);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      bus.i_flit_valid = 1'b0; bus.i_flit_vc = 1'b0; bus.i_flit = '0;
      bus.i_sa_grant   = '0;   bus.i_xbar_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, " flit_valid"}, bus.o_flit_valid, 0);
      check({tag, " credit"},     bus.o_credit_valid, 0);
      check({tag, " state"},      bus.o_vc_state, 0);
      check({tag, " req"},        bus.o_sa_req, 0);
      check({tag, " sa_route"},   bus.o_sa_route, 0);
      check({tag, " done"},       bus.o_packet_done, 0);
      check({tag, " err"},        bus.o_err, 0);
   endtask

   vec_t tbl [10];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] h, b1, b2, t;
      logic [31:0] xf [4];
      logic        xv [4];
      logic [31:0] f5;

      reset_n = 1'b0;
      bus.i_flit_valid = 1'b0; bus.i_flit_vc = 1'b0; bus.i_flit = '0;
      bus.i_sa_grant   = '0;   bus.i_xbar_ready = 1'b0;
      #12;
      check_zero("reset");
      do_reset();

      // Test 1: four-flit packet on VC0, route 5, granted at first request, crossbar always ready.
      h  = fl(2'b00, 26'h11, 3'd5);
      b1 = fl(2'b01, 26'h22, 3'd0);
      b2 = fl(2'b01, 26'h33, 3'd0);
      t  = fl(2'b10, 26'h44, 3'd0);
      //          fv vc flit  gnt rdy  req sar fv flit  fvc frt cv cvc state  done  err
      tbl[0] = '{1, 0, h,   0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0};
      tbl[1] = '{1, 0, b1,  0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0};
      tbl[2] = '{1, 0, b2,  0, 1,  0, 0, 0, 0,  0, 0, 0, 0, 4'b0001, 0, 0};
      tbl[3] = '{1, 0, t,   1, 1,  1, 5, 0, 0,  0, 0, 0, 0, 4'b0010, 0, 0};
      tbl[4] = '{0, 0, 0,   0, 1,  0, 5, 1, h,  0, 5, 0, 0, 4'b0011, 0, 0};
      tbl[5] = '{0, 0, 0,   0, 1,  0, 5, 1, b1, 0, 5, 1, 0, 4'b0011, 0, 0};
      tbl[6] = '{0, 0, 0,   0, 1,  0, 5, 1, b2, 0, 5, 1, 0, 4'b0011, 0, 0};
      tbl[7] = '{0, 0, 0,   0, 1,  0, 5, 1, t,  0, 5, 1, 0, 4'b0011, 1, 0};
      tbl[8] = '{0, 0, 0,   0, 1,  0, 5, 0, 0,  0, 0, 1, 0, 4'b0000, 0, 0};
      tbl[9] = '{0, 0, 0,   0, 1,  0, 5, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0};
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].fv, tbl[i].vc, tbl[i].flit, tbl[i].grant, tbl[i].ready);
         check($sformatf("t1[%0d] req", i),      bus.o_sa_req,       tbl[i].e_req);
         check($sformatf("t1[%0d] sa_route", i), bus.o_sa_route,     tbl[i].e_sa_route);
         check($sformatf("t1[%0d] fv", i),       bus.o_flit_valid,   tbl[i].e_fv);
         if (tbl[i].e_fv) begin
            check($sformatf("t1[%0d] flit", i),   bus.o_flit,         tbl[i].e_flit);
            check($sformatf("t1[%0d] fvc", i),    bus.o_flit_vc,      tbl[i].e_fvc);
            check($sformatf("t1[%0d] froute", i), bus.o_flit_route,   tbl[i].e_froute);
         end
         check($sformatf("t1[%0d] credit", i),   bus.o_credit_valid, tbl[i].e_cv);
         if (tbl[i].e_cv) check($sformatf("t1[%0d] credit_vc", i), bus.o_credit_vc, tbl[i].e_cvc);
         check($sformatf("t1[%0d] state", i),    bus.o_vc_state,     tbl[i].e_state);
         check($sformatf("t1[%0d] done", i),     bus.o_packet_done,  tbl[i].e_done);
         check($sformatf("t1[%0d] err", i),      bus.o_err,          tbl[i].e_err);
      end

      // Test 2: two-flit packets on both VCs, both ACTIVE before the crossbar opens.
      do_reset();
      xf[0] = fl(2'b00, 26'h1, 3'd2); xv[0] = 1'b0;
      xf[1] = fl(2'b00, 26'h2, 3'd6); xv[1] = 1'b1;
      xf[2] = fl(2'b10, 26'h3, 3'd0); xv[2] = 1'b0;
      xf[3] = fl(2'b10, 26'h4, 3'd0); xv[3] = 1'b1;
      for (int i = 0; i < 4; i++) drive(1'b1, xv[i], xf[i], 2'b11, 1'b0);
      idle(2'b11, 1'b0);
      idle(2'b11, 1'b0);
      check("t2 both active", bus.o_vc_state, 4'b1111);
      check("t2 held valid", bus.o_flit_valid, 1);
      for (int i = 0; i < 4; i++) begin
         idle(2'b00, 1'b1);
         check($sformatf("t2[%0d] fv", i),   bus.o_flit_valid, 1);
         check($sformatf("t2[%0d] fvc", i),  bus.o_flit_vc, xv[i]);
         check($sformatf("t2[%0d] flit", i), bus.o_flit, xf[i]);
         check($sformatf("t2[%0d] froute", i), bus.o_flit_route, xv[i] ? 3'd6 : 3'd2);
         check($sformatf("t2[%0d] credit", i), bus.o_credit_valid, (i > 0));
         if (i > 0) check($sformatf("t2[%0d] credit_vc", i), bus.o_credit_vc, xv[i-1]);
         check($sformatf("t2[%0d] done", i), bus.o_packet_done,
               (i == 2) ? 2'b01 : (i == 3) ? 2'b10 : 2'b00);
      end
      idle(2'b00, 1'b1);
      check("t2 drained fv", bus.o_flit_valid, 0);
      check("t2 last credit", bus.o_credit_valid, 1);
      check("t2 last credit_vc", bus.o_credit_vc, 1);
      check("t2 idle", bus.o_vc_state, 4'b0000);

      // Test 3: five flits into VC1 (overflow on the fifth), then a BODY on idle VC0 whose
      // discard must wait until VC1 stops transferring.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b1, fl((i == 0) ? 2'b00 : 2'b01, 26'h50 + 26'(i), 3'd4), 2'b00, 1'b0);
         check($sformatf("t3 write%0d err", i), bus.o_err, (i == 4) ? 2'b01 : 2'b00);
      end
      check("t3 req", bus.o_sa_req, 2'b10);
      drive(1'b1, 1'b0, fl(2'b01, 26'h60, 3'd0), 2'b10, 1'b0);
      check("t3 no err", bus.o_err, 0);
      for (int i = 0; i < 4; i++) begin
         idle(2'b00, 1'b1);
         f5 = fl((i == 0) ? 2'b00 : 2'b01, 26'h50 + 26'(i), 3'd4);
         check($sformatf("t3[%0d] flit", i), bus.o_flit, f5);
         check($sformatf("t3[%0d] fvc", i), bus.o_flit_vc, 1);
         check($sformatf("t3[%0d] err deferred", i), bus.o_err, 0);
         if (i > 0) check($sformatf("t3[%0d] credit_vc", i), bus.o_credit_vc, 1);
      end
      idle(2'b00, 1'b1);
      check("t3 fifo held 4", bus.o_flit_valid, 0);
      check("t3 stay active", bus.o_vc_state, 4'b1100);
      check("t3 discard err", bus.o_err, 2'b10);
      check("t3 credit vc1", bus.o_credit_vc, 1);
      idle(2'b00, 1'b1);
      check("t3 discard credit", bus.o_credit_valid, 1);
      check("t3 discard credit_vc", bus.o_credit_vc, 0);
      check("t3 err clear", bus.o_err, 0);

      // Test 4: BODY on an idle VC0 with no competing transfer.
      do_reset();
      drive(1'b1, 1'b0, fl(2'b01, 26'h99, 3'd0), 2'b00, 1'b1);
      check("t4 err before", bus.o_err, 0);
      idle(2'b00, 1'b1);
      check("t4 err pulse", bus.o_err, 2'b10);
      check("t4 state idle", bus.o_vc_state, 0);
      check("t4 no credit yet", bus.o_credit_valid, 0);
      idle(2'b00, 1'b1);
      check("t4 credit", bus.o_credit_valid, 1);
      check("t4 credit_vc", bus.o_credit_vc, 0);
      check("t4 err gone", bus.o_err, 0);
      check("t4 still idle", bus.o_vc_state, 0);
      idle(2'b00, 1'b1);
      check("t4 single credit", bus.o_credit_valid, 0);

      // Test 5: HEAD_TAIL held by crossbar backpressure for three cycles.
      do_reset();
      f5 = fl(2'b11, 26'h77, 3'd2);
      drive(1'b1, 1'b0, f5, 2'b00, 1'b0);
      idle(2'b00, 1'b0);
      idle(2'b00, 1'b0);
      idle(2'b01, 1'b0);
      check("t5 req", bus.o_sa_req, 2'b01);
      for (int i = 0; i < 3; i++) begin
         idle(2'b00, 1'b0);
         check($sformatf("t5 stall%0d fv", i), bus.o_flit_valid, 1);
         check($sformatf("t5 stall%0d flit", i), bus.o_flit, f5);
         check($sformatf("t5 stall%0d done", i), bus.o_packet_done, 0);
      end
      idle(2'b00, 1'b1);
      check("t5 done", bus.o_packet_done, 2'b01);
      check("t5 route", bus.o_flit_route, 3'd2);
      idle(2'b00, 1'b1);
      check("t5 empty", bus.o_flit_valid, 0);
      check("t5 credit", bus.o_credit_valid, 1);
      check("t5 idle", bus.o_vc_state, 0);
      idle(2'b00, 1'b1);
      check("t5 one credit", bus.o_credit_valid, 0);

      // Test 6: asynchronous reset while VC0 is ACTIVE with two flits still buffered.
      do_reset();
      drive(1'b1, 1'b0, fl(2'b00, 26'h5, 3'd3), 2'b00, 1'b0);
      drive(1'b1, 1'b0, fl(2'b01, 26'h6, 3'd0), 2'b00, 1'b0);
      drive(1'b1, 1'b0, fl(2'b01, 26'h7, 3'd0), 2'b00, 1'b0);
      idle(2'b01, 1'b0);
      idle(2'b00, 1'b1);
      idle(2'b00, 1'b0);
      check("t6 pre credit", bus.o_credit_valid, 1);
      check("t6 pre active", bus.o_vc_state, 4'b0011);
      #1 reset_n = 1'b0;
      #1 check_zero("t6 in reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(2'b01, 1'b1);
         check($sformatf("t6 after%0d fv", i), bus.o_flit_valid, 0);
         check($sformatf("t6 after%0d credit", i), bus.o_credit_valid, 0);
         check($sformatf("t6 after%0d state", i), bus.o_vc_state, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
